// File: rtl/led_anim_pkg.sv
// Shared encodings for the LED animation engine: mode codes, FSM states and default bar size.
package led_anim_pkg;

  localparam int N_LED_DEF = 10;

  localparam logic [1:0] MODE_BAR    = 2'd0;
  localparam logic [1:0] MODE_CHASE  = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_OFF    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN_UP   = 2'd1,
    ST_RUN_DOWN = 2'd2,
    ST_GAP      = 2'd3
  } state_t;

endpackage

// File: rtl/led_anim_render.sv
// Combinational pattern generator: maps (mode, state, pos) to an MSB-aligned LED pattern.
module led_anim_render
  import led_anim_pkg::*;
#(
  parameter int N_LED = N_LED_DEF,
  parameter int PW    = $clog2(N_LED + 1)
) (
  input  logic [1:0]       mode,
  input  state_t           state,
  input  logic [PW-1:0]    pos,
  output logic [N_LED-1:0] pattern
);

  // pattern selection; only running states light anything
  always_comb begin
    pattern = '0;
    case (state)
      ST_RUN_UP, ST_RUN_DOWN: begin
        case (mode)
          MODE_BAR: begin
            for (int i = 0; i < N_LED; i++) begin
              pattern[i] = (i >= (N_LED - int'(pos)));
            end
          end
          MODE_CHASE, MODE_BOUNCE: begin
            for (int i = 0; i < N_LED; i++) begin
              pattern[i] = (i == (N_LED - int'(pos)));
            end
          end
          default: pattern = '0;
        endcase
      end
      default: pattern = '0;
    endcase
  end

endmodule

// File: rtl/led_anim_engine.sv
// LED bar animation engine: step prescaler, position/direction FSM and registered rendering.
module led_anim_engine
  import led_anim_pkg::*;
#(
  parameter int N_LED = N_LED_DEF,
  parameter int DIV_W = 24,
  parameter int GAP_W = 8,
  parameter int PW    = $clog2(N_LED + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [PW-1:0]    peak,
  input  logic [GAP_W-1:0] gap,
  input  logic [DIV_W-1:0] div,
  output logic [N_LED-1:0] led,
  output logic             step_tick,
  output logic             cycle_done
);

  state_t           state_r, state_n;
  logic [DIV_W-1:0] pc_r, pc_n;
  logic [PW-1:0]    pos_r, pos_n;
  logic [GAP_W-1:0] gcnt_r, gcnt_n;
  logic [1:0]       mode_q_r, mode_n;
  logic [PW-1:0]    peak_q_r, peak_n;
  logic [GAP_W-1:0] gap_q_r, gap_n;
  logic [N_LED-1:0] led_r;
  logic             step_tick_r, cycle_done_r;

  logic             step_s, done_s, restart_s;
  logic [PW-1:0]    peak_cl_s;
  logic [N_LED-1:0] pattern_s;

  assign step_s    = (state_r != ST_IDLE) && (pc_r >= div);
  assign peak_cl_s = (peak == '0) ? PW'(1) :
                     ((peak > PW'(N_LED)) ? PW'(N_LED) : peak);

  // next-state, counter and configuration-latch logic
  always_comb begin
    state_n   = state_r;
    pos_n     = pos_r;
    gcnt_n    = gcnt_r;
    pc_n      = '0;
    mode_n    = mode_q_r;
    peak_n    = peak_q_r;
    gap_n     = gap_q_r;
    done_s    = 1'b0;
    restart_s = 1'b0;
    if (!en) begin
      state_n = ST_IDLE;
      pos_n   = '0;
      gcnt_n  = '0;
      pc_n    = '0;
    end else begin
      if (step_s || (state_r == ST_IDLE)) begin
        pc_n = '0;
      end else begin
        pc_n = pc_r + DIV_W'(1);
      end
      case (state_r)
        ST_IDLE: restart_s = 1'b1;
        ST_RUN_UP: begin
          if (!step_s) begin
            pos_n = pos_r;
          end else if (pos_r < peak_q_r) begin
            pos_n = pos_r + PW'(1);
          end else if ((mode_q_r == MODE_CHASE) || (peak_q_r == PW'(1))) begin
            done_s = 1'b1;
          end else begin
            state_n = ST_RUN_DOWN;
            pos_n   = peak_q_r - PW'(1);
          end
        end
        ST_RUN_DOWN: begin
          if (!step_s) begin
            pos_n = pos_r;
          end else if (pos_r > PW'(1)) begin
            pos_n = pos_r - PW'(1);
          end else begin
            done_s = 1'b1;
          end
        end
        ST_GAP: begin
          if (!step_s) begin
            gcnt_n = gcnt_r;
          end else if (gcnt_r > GAP_W'(1)) begin
            gcnt_n = gcnt_r - GAP_W'(1);
          end else begin
            restart_s = 1'b1;
          end
        end
        default: state_n = ST_IDLE;
      endcase
      // a finished cycle either restarts directly or parks in the dark gap
      if (done_s && (gap_q_r != '0)) begin
        state_n = ST_GAP;
        gcnt_n  = gap_q_r;
      end else if (done_s || restart_s) begin
        state_n = ST_RUN_UP;
        pos_n   = PW'(1);
        gcnt_n  = '0;
        mode_n  = mode;
        peak_n  = peak_cl_s;
        gap_n   = gap;
      end else begin
        mode_n = mode_q_r;
        peak_n = peak_q_r;
        gap_n  = gap_q_r;
      end
    end
  end

  // rendering uses the upcoming state so led lands together with step_tick
  led_anim_render #(
    .N_LED (N_LED),
    .PW    (PW)
  ) u_render (
    .mode    (mode_n),
    .state   (state_n),
    .pos     (pos_n),
    .pattern (pattern_s)
  );

  // state, counters, latched configuration and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= '0;
      pos_r        <= '0;
      gcnt_r       <= '0;
      mode_q_r     <= 2'd0;
      peak_q_r     <= '0;
      gap_q_r      <= '0;
      led_r        <= '0;
      step_tick_r  <= 1'b0;
      cycle_done_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      pc_r         <= pc_n;
      pos_r        <= pos_n;
      gcnt_r       <= gcnt_n;
      mode_q_r     <= mode_n;
      peak_q_r     <= peak_n;
      gap_q_r      <= gap_n;
      led_r        <= pattern_s;
      step_tick_r  <= step_s & en;
      cycle_done_r <= done_s;
    end
  end

  assign led        = led_r;
  assign step_tick  = step_tick_r;
  assign cycle_done = cycle_done_r;

endmodule
